// File: rtl/pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter, next-PC candidate generation and instruction
//            fetch handshake feeding decode. Optional macro PC_ALIGN_CHECK_EN
//            traps misaligned targets into a sticky fault and HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  PC_Sel,
    input  logic [31:0] Branch_Offset,
    input  logic [25:0] Jump_Index,
    input  logic [31:0] Reg_Target,
    input  logic        Advance,
    input  logic        Stall,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic [31:0] PC,
    output logic [31:0] PC_Plus4,
    output logic [31:0] Retired_Count,
    output logic        Align_Fault
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        retire;

    assign pc_plus4 = pc_q + 32'd4;
    assign retire   = (state_q == ST_HOLD) && Advance && !Stall;

    always_comb begin
        next_pc = pc_plus4;
        case (PC_Sel)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc_plus4 + (Branch_Offset << 2);
            2'b10:   next_pc = {pc_plus4[31:28], Jump_Index, 2'b00};
            default: next_pc = Reg_Target;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic align_fault_q, align_fault_d;
    logic misaligned;

    assign misaligned = (next_pc[1:0] != 2'b00);
`endif

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_d         = instr_q;
        instr_valid_d   = instr_valid_q;
        retired_count_d = retired_count_q;
`ifdef PC_ALIGN_CHECK_EN
        align_fault_d   = align_fault_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (IMem_Ack) begin
                    instr_d       = IMem_Data;
                    instr_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (retire) begin
                    retired_count_d = retired_count_q + 32'd1;
                    instr_valid_d   = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                    // The faulting instruction still counts as retired.
                    if (misaligned) begin
                        align_fault_d = 1'b1;
                        state_d       = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
`else
                    pc_d    = next_pc & ~32'h3;
                    state_d = ST_FETCH;
`endif
                end
            end
            ST_HALT: begin
                instr_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q         <= ST_BOOT;
            pc_q            <= RESET_PC;
            instr_q         <= 32'h0;
            instr_valid_q   <= 1'b0;
            retired_count_q <= 32'h0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_q         <= instr_d;
            instr_valid_q   <= instr_valid_d;
            retired_count_q <= retired_count_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            align_fault_q <= 1'b0;
        end else begin
            align_fault_q <= align_fault_d;
        end
    end

    assign Align_Fault = align_fault_q;
`else
    assign Align_Fault = 1'b0;
`endif

    // Request is decoded from state so a reset drops it without waiting for a clock.
    assign IMem_Req      = (state_q == ST_FETCH);
    assign IMem_Addr     = pc_q;
    assign Instr         = instr_q;
    assign Instr_Valid   = instr_valid_q;
    assign PC            = pc_q;
    assign PC_Plus4      = pc_plus4;
    assign Retired_Count = retired_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Self-checking bench for pc_fetch_unit: directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [1:0]  PC_Sel = 2'b00;
    logic [31:0] Branch_Offset = 32'h0;
    logic [25:0] Jump_Index = 26'h0;
    logic [31:0] Reg_Target = 32'h0;
    logic        Advance = 1'b0;
    logic        Stall = 1'b0;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack = 1'b0;
    logic [31:0] IMem_Data = 32'h0;
    logic [31:0] Instr;
    logic        Instr_Valid;
    logic [31:0] PC;
    logic [31:0] PC_Plus4;
    logic [31:0] Retired_Count;
    logic        Align_Fault;

    int checks = 0;
    int errors = 0;

    pc_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST(RST), .PC_Sel(PC_Sel), .Branch_Offset(Branch_Offset),
        .Jump_Index(Jump_Index), .Reg_Target(Reg_Target), .Advance(Advance),
        .Stall(Stall), .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Ack(IMem_Ack), .IMem_Data(IMem_Data), .Instr(Instr),
        .Instr_Valid(Instr_Valid), .PC(PC), .PC_Plus4(PC_Plus4),
        .Retired_Count(Retired_Count), .Align_Fault(Align_Fault)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 booting, 1 waiting for memory, 2 holding an instruction, 3 halted.
    int          m_phase = 0;
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_cnt   = 32'h0;
    logic        m_fault = 1'b0;

    initial forever begin
        logic [31:0] target;
        @(posedge CLK or posedge RST);
        if (RST) begin
            m_phase = 0; m_pc = RESET_PC; m_instr = 0; m_valid = 0; m_cnt = 0; m_fault = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (IMem_Ack) begin
                m_instr = IMem_Data; m_valid = 1; m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (Advance && !Stall) begin
                case (PC_Sel)
                    2'd0: target = m_pc + 4;
                    2'd1: target = m_pc + 4 + Branch_Offset * 4;
                    2'd2: target = ((m_pc + 4) & 32'hF000_0000) + {6'd0, Jump_Index} * 4;
                    default: target = Reg_Target;
                endcase
                m_cnt = m_cnt + 1;
                m_valid = 0;
`ifdef PC_ALIGN_CHECK_EN
                if (target % 4 != 0) begin
                    m_fault = 1; m_phase = 3;
                end else begin
                    m_pc = target; m_phase = 1;
                end
`else
                m_pc = target - (target % 4);
                m_phase = 1;
`endif
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        chk("req",      {31'd0, IMem_Req},    {31'd0, m_phase == 1});
        chk("addr",     IMem_Addr,            m_pc);
        chk("pc",       PC,                   m_pc);
        chk("pc_plus4", PC_Plus4,             m_pc + 4);
        chk("instr",    Instr,                m_instr);
        chk("valid",    {31'd0, Instr_Valid}, {31'd0, m_valid});
        chk("count",    Retired_Count,        m_cnt);
        chk("fault",    {31'd0, Align_Fault}, {31'd0, m_fault});
    end

    initial forever begin
        @(posedge CLK);
        #1 IMem_Data = $urandom;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid();
        int k = 0;
        while (Instr_Valid !== 1'b1 && k < 30) begin
            cyc(1);
            k++;
        end
        if (k >= 30) chk("wait_valid_timeout", {31'd0, Instr_Valid}, 32'd1);
    endtask

    task automatic retire(input logic [1:0] sel, input logic [31:0] off,
                          input logic [25:0] ji, input logic [31:0] rt);
        wait_valid();
        PC_Sel = sel; Branch_Offset = off; Jump_Index = ji; Reg_Target = rt;
        Advance = 1'b1; Stall = 1'b0;
        cyc(1);
        Advance = 1'b0;
    endtask

    initial begin
        #1 RST = 1'b1;
        cyc(2);
        chk("reset_pc",  PC, RESET_PC);
        chk("reset_req", {31'd0, IMem_Req}, 32'd0);
        RST = 1'b0;
        IMem_Ack = 1'b1;
        cyc(1);
        chk("boot_req",  {31'd0, IMem_Req}, 32'd1);
        chk("boot_addr", IMem_Addr, 32'h0);

        retire(2'd0, 0, 0, 0);
        chk("seq_pc1", PC, 32'h4);
        retire(2'd0, 0, 0, 0);
        chk("seq_pc2", PC, 32'h8);
        chk("seq_cnt", Retired_Count, 32'd2);

        retire(2'd3, 0, 0, 32'h100);
        retire(2'd1, 32'hFFFF_FFFC, 0, 0);
        chk("branch_back_addr", IMem_Addr, 32'hF4);

        retire(2'd3, 0, 0, 32'hA000_0010);
        retire(2'd2, 0, 26'h40, 0);
        chk("jump_pc", PC, 32'hA000_0100);
        retire(2'd3, 0, 0, 32'h0040_0000);
        chk("jr_pc", PC, 32'h0040_0000);

        retire(2'd3, 0, 0, 32'hFFFF_FFFC);
        retire(2'd0, 0, 0, 0);
        chk("wrap_pc", PC, 32'h0);

        // Memory answers only after four request cycles.
        IMem_Ack = 1'b0;
        chk("dly_req0", {31'd0, IMem_Req}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            cyc(1);
            chk("dly_req",  {31'd0, IMem_Req}, 32'd1);
            chk("dly_addr", IMem_Addr, 32'h0);
        end
        IMem_Ack = 1'b1;
        cyc(1);
        IMem_Ack = 1'b0;
        chk("dly_valid", {31'd0, Instr_Valid}, 32'd1);

        PC_Sel = 2'd0; Advance = 1'b1; Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("stall_pc",  PC, 32'h0);
            chk("stall_cnt", Retired_Count, 32'd9);
        end
        Stall = 1'b0;
        cyc(1);
        Advance = 1'b0;
        chk("unstall_pc",  PC, 32'h4);
        chk("unstall_cnt", Retired_Count, 32'd10);

        IMem_Ack = 1'b1;
        retire(2'd3, 0, 0, 32'h100);
        retire(2'd3, 0, 0, 32'h102);
        chk("align_pc", PC, 32'h100);
        chk("align_cnt", Retired_Count, 32'd12);
`ifdef PC_ALIGN_CHECK_EN
        chk("align_fault", {31'd0, Align_Fault}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("halt_req", {31'd0, IMem_Req}, 32'd0);
        end
`else
        chk("align_fault", {31'd0, Align_Fault}, 32'd0);
        cyc(1);
        chk("align_addr", IMem_Addr, 32'h100);
`endif

        // Reset in the middle of a pending fetch.
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        IMem_Ack = 1'b0;
        cyc(1);
        chk("mid_req_before", {31'd0, IMem_Req}, 32'd1);
        #2 RST = 1'b1;
        #1 chk("mid_req_dropped", {31'd0, IMem_Req}, 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        IMem_Ack = 1'b1;
        cyc(1);
        chk("mid_instr", Instr, 32'h0);
        chk("mid_valid", {31'd0, Instr_Valid}, 32'd0);

        for (int i = 0; i < 2000; i++) begin
            IMem_Ack      = ($urandom_range(0, 1) == 1);
            Advance       = ($urandom_range(0, 1) == 1);
            Stall         = ($urandom_range(0, 3) == 0);
            PC_Sel        = 2'($urandom_range(0, 3));
            Branch_Offset = 32'($urandom_range(0, 255)) - 32'd128;
            Jump_Index    = 26'($urandom);
            Reg_Target    = ($urandom & 32'hFFFF_FFFC) |
                            (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
            RST           = ($urandom_range(0, 149) == 0);
            cyc(1);
        end
        RST = 1'b0; Advance = 1'b0; IMem_Ack = 1'b0;
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
